// File: rtl/master_port_if.sv
`default_nettype none
// ============================================================================
// Module   : master_port_if
// Desc     : Device-side request handshake and serial bus signals of the
//            master port, bundled with master (port) and slave (environment)
//            views.
// Revision : 1.0 - initial release
// ============================================================================
interface master_port_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  // device request side
  logic                  dvalid;
  logic                  dmode;
  logic [ADDR_WIDTH-1:0] daddr;
  logic [DATA_WIDTH-1:0] dwdata;
  logic                  dready;
  logic [DATA_WIDTH-1:0] drdata;
  logic                  ddone;
  logic                  derr;
  // arbiter / serial bus side
  logic                  mbreq;
  logic                  mgrant;
  logic                  mwdata;
  logic                  mmode;
  logic                  mvalid;
  logic                  srdata;
  logic                  svalid;
  logic                  sready;
  logic                  ssplit;

  modport master (
    input  dvalid, dmode, daddr, dwdata, mgrant, srdata, svalid, sready, ssplit,
    output dready, drdata, ddone, derr, mbreq, mwdata, mmode, mvalid
  );

  modport slave (
    output dvalid, dmode, daddr, dwdata, mgrant, srdata, svalid, sready, ssplit,
    input  dready, drdata, ddone, derr, mbreq, mwdata, mmode, mvalid
  );
endinterface
`default_nettype wire

// File: rtl/master_port.sv
`default_nettype none
// ============================================================================
// Module   : master_port
// Desc     : Serial bus master. Accepts one device request, arbitrates for the
//            bus, shifts the address (and write data) out LSB first, and for
//            reads collects the serial response with split and timeout support.
// Revision : 1.0 - initial release
// ============================================================================
module master_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic          clk,
  input  logic          rst,
  master_port_if.master bus
);

  localparam int C_MAXW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int C_CNT_W = (C_MAXW > 1) ? $clog2(C_MAXW) : 1;
  localparam int C_TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [C_CNT_W-1:0] C_ADDR_LAST = C_CNT_W'(ADDR_WIDTH - 1);
  localparam logic [C_CNT_W-1:0] C_DATA_LAST = C_CNT_W'(DATA_WIDTH - 1);
  localparam logic [C_TO_W-1:0]  C_TO_LAST   = C_TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    ADDR  = 3'd2,
    WDATA = 3'd3,
    RWAIT = 3'd4,
    SPLIT = 3'd5,
    RDATA = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic                  r_mode;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rword;
  logic [DATA_WIDTH-1:0] r_drdata;
  logic [C_CNT_W-1:0]    r_cnt;
  logic [C_TO_W-1:0]     r_tcnt;

  logic                  w_accept;
  logic                  w_cnt_clr;
  logic                  w_cnt_inc;
  logic                  w_tcnt_inc;
  logic                  w_rbit;
  logic                  w_rlast;
  logic [ADDR_WIDTH-1:0] w_addr_sh;
  logic [DATA_WIDTH-1:0] w_wdata_sh;
  logic [DATA_WIDTH-1:0] w_rword_nxt;

  // r_cnt selects the current serial bit for address, write data and read data
  assign w_addr_sh   = r_addr >> r_cnt;
  assign w_wdata_sh  = r_wdata >> r_cnt;
  assign w_rlast     = (r_cnt == C_DATA_LAST);
  // r_rword is cleared on acceptance, so OR-ing the new bit in assembles the word
  assign w_rword_nxt = r_rword | (DATA_WIDTH'(bus.srdata) << r_cnt);
  assign bus.drdata  = r_drdata;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state, bus outputs and datapath strobes
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_tcnt_inc  = 1'b0;
    w_rbit      = 1'b0;
    bus.dready  = 1'b0;
    bus.ddone   = 1'b0;
    bus.derr    = 1'b0;
    bus.mbreq   = 1'b0;
    bus.mvalid  = 1'b0;
    bus.mmode   = 1'b0;
    bus.mwdata  = 1'b0;
    case (r_state)
      IDLE: begin
        bus.dready = 1'b1;
        if (bus.dvalid) begin
          w_accept = 1'b1;
          w_next   = REQ;
        end
      end
      REQ: begin
        bus.mbreq = 1'b1;
        if (bus.mgrant && bus.sready) begin
          w_cnt_clr = 1'b1;
          w_next    = ADDR;
        end
      end
      ADDR: begin
        bus.mbreq  = 1'b1;
        bus.mvalid = 1'b1;
        bus.mmode  = r_mode;
        bus.mwdata = w_addr_sh[0];
        if (r_cnt == C_ADDR_LAST) begin
          w_cnt_clr = 1'b1;
          w_next    = r_mode ? WDATA : RWAIT;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      WDATA: begin
        bus.mbreq  = 1'b1;
        bus.mvalid = 1'b1;
        bus.mmode  = r_mode;
        bus.mwdata = w_wdata_sh[0];
        if (r_cnt == C_DATA_LAST) begin
          w_cnt_clr = 1'b1;
          w_next    = DONE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      RWAIT: begin
        bus.mbreq = 1'b1;
        // a response bit wins over a split, and both win over the timeout
        if (bus.svalid) begin
          w_rbit = 1'b1;
          w_next = w_rlast ? DONE : RDATA;
        end else if (bus.ssplit) begin
          w_next = SPLIT;
        end else if (r_tcnt == C_TO_LAST) begin
          bus.derr = 1'b1;
          w_next   = IDLE;
        end else begin
          w_tcnt_inc = 1'b1;
        end
      end
      SPLIT: begin
        // bus released and timeout frozen until the slave resumes
        if (bus.svalid) begin
          w_rbit = 1'b1;
          w_next = w_rlast ? DONE : RDATA;
        end
      end
      RDATA: begin
        bus.mbreq = 1'b1;
        if (bus.svalid) begin
          w_rbit = 1'b1;
          if (w_rlast) begin
            w_next = DONE;
          end
        end
      end
      DONE: begin
        bus.ddone = 1'b1;
        w_next    = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // request latch, bit/timeout counters and read-word assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rword  <= '0;
      r_drdata <= '0;
      r_cnt    <= '0;
      r_tcnt   <= '0;
    end else begin
      if (w_accept) begin
        r_mode  <= bus.dmode;
        r_addr  <= bus.daddr;
        r_wdata <= bus.dwdata;
        r_rword <= '0;
        r_tcnt  <= '0;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc || (w_rbit && !w_rlast)) begin
        r_cnt <= r_cnt + C_CNT_W'(1);
      end
      if (w_tcnt_inc) begin
        r_tcnt <= r_tcnt + C_TO_W'(1);
      end
      if (w_rbit) begin
        r_rword <= w_rword_nxt;
        if (w_rlast) begin
          r_drdata <= w_rword_nxt;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_master_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_master_port
// Desc     : Self-checking bench for master_port: directed bus scenarios plus
//            randomized transactions checked against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_master_port;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  master_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // model of the last successfully read word
  logic [DW-1:0] exp_drdata;

  // observations gathered by run_txn
  logic [AW+DW-1:0] got_bits;
  int nbits, first_mv, last_mv, last_sv, mmode_bad, mbreq_low, dready_bad;
  int done_cnt, done_cyc, err_cnt, err_cyc, drdata_bad;
  bit timed_out;
  logic end_dready;
  logic [DW-1:0] end_dr;

  task automatic drive_idle;
    bus.dvalid = 1'b0; bus.dmode = 1'b0; bus.daddr = '0; bus.dwdata = '0;
    bus.mgrant = 1'b0; bus.sready = 1'b1; bus.srdata = 1'b0;
    bus.svalid = 1'b0; bus.ssplit = 1'b0;
  endtask

  // One device transaction with an arbiter/slave environment. Inputs change
  // just after the falling edge; outputs are sampled 1ns later.
  task automatic run_txn(input bit mode, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int gd, input int pre,
                         input int nsplit, input logic [DW-1:0] rdata,
                         input bit respond, input bit noise);
    int cyc, rw, k;
    int unsigned r;
    bit fin;
    got_bits = '0; nbits = 0; first_mv = -1; last_mv = -1; last_sv = -1;
    mmode_bad = 0; mbreq_low = 0; dready_bad = 0; done_cnt = 0; done_cyc = -1;
    err_cnt = 0; err_cyc = -1; drdata_bad = 0; timed_out = 1'b0;
    cyc = 0; rw = -1; k = 0; fin = 1'b0;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      if (cyc == 0) begin
        bus.dvalid = 1'b1; bus.dmode = mode; bus.daddr = addr; bus.dwdata = wdata;
      end else begin
        bus.dvalid = noise ? 1'($urandom % 2) : 1'b0;
        bus.dmode  = 1'($urandom % 2);
        bus.daddr  = AW'($urandom);
        bus.dwdata = DW'($urandom);
      end
      // arbiter: withhold mgrant&&sready for gd cycles of REQ
      if (cyc >= 1 && cyc <= gd) begin
        r = noise ? ($urandom % 3) : 0;
        bus.mgrant = (r == 1);
        bus.sready = (r == 2) || !noise;
      end else if (cyc == gd + 1) begin
        bus.mgrant = 1'b1; bus.sready = 1'b1;
      end else begin
        bus.mgrant = noise ? 1'($urandom % 2) : 1'b0;
        bus.sready = 1'b1;
      end
      // slave response schedule, relative to the first cycle after the address
      bus.srdata = noise ? 1'($urandom % 2) : 1'b0;
      bus.svalid = 1'b0;
      bus.ssplit = 1'b0;
      if (rw < 0) begin
        bus.svalid = noise ? 1'($urandom % 2) : 1'b0;
        bus.ssplit = noise ? 1'($urandom % 2) : 1'b0;
      end else if (respond && rw >= pre) begin
        if (rw < pre + nsplit) begin
          bus.ssplit = 1'b1;
        end else if (k < DW) begin
          bus.ssplit = noise ? 1'($urandom % 2) : 1'b0;
          if (!(noise && k > 0 && ($urandom % 3) == 0)) begin
            bus.svalid = 1'b1;
            bus.srdata = rdata[k];
            k++;
            last_sv = cyc;
          end
        end
      end
      #1;
      if (bus.mvalid === 1'b1) begin
        if (nbits < AW + DW) got_bits[nbits] = bus.mwdata;
        nbits++;
        if (first_mv < 0) first_mv = cyc;
        last_mv = cyc;
        if (bus.mmode !== mode) mmode_bad++;
      end
      if (bus.dready !== (cyc == 0)) dready_bad++;
      if (cyc > 0 && bus.ddone !== 1'b1 && bus.mbreq !== 1'b1) mbreq_low++;
      if (bus.ddone === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (bus.derr === 1'b1) begin err_cnt++; err_cyc = cyc; end
      if (done_cnt == 0 && bus.drdata !== exp_drdata) drdata_bad++;
      if (bus.ddone === 1'b1 || bus.derr === 1'b1) fin = 1'b1;
      if (rw >= 0) rw++;
      else if (!mode && nbits == AW) rw = 0;
      cyc++;
    end
    timed_out = !fin;
    @(negedge clk);
    drive_idle();
    #1;
    end_dready = bus.dready;
    end_dr = bus.drdata;
    if (!mode && respond) exp_drdata = rdata;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus.dready, bus.mbreq, bus.mvalid, bus.ddone, bus.derr, bus.mwdata, bus.mmode} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 1000000",
               {bus.dready, bus.mbreq, bus.mvalid, bus.ddone, bus.derr, bus.mwdata, bus.mmode});
    end
    checks++;
    if (bus.drdata !== '0) begin
      errors++; $display("FAIL reset_drdata: got %h required 00", bus.drdata);
    end
    exp_drdata = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write;
    logic [DW-1:0] old;
    old = exp_drdata;
    run_txn(1'b1, 12'h5A3, 8'hC6, 0, 0, 0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL write_timeout: no completion in 400 cycles"); end
    checks++;
    if (nbits != 20 || last_mv - first_mv != 19) begin
      errors++; $display("FAIL write_mvalid_run: got %0d bits over %0d cycles required 20/20", nbits, last_mv - first_mv + 1);
    end
    checks++;
    if (got_bits !== 20'hC65A3) begin
      errors++; $display("FAIL write_bits: got %h required c65a3", got_bits);
    end
    checks++;
    if (mmode_bad != 0) begin errors++; $display("FAIL write_mmode: %0d cycles with mmode!=1", mmode_bad); end
    checks++;
    if (done_cnt != 1 || done_cyc != last_mv + 1) begin
      errors++; $display("FAIL write_ddone: got %0d pulses at %0d required 1 at %0d", done_cnt, done_cyc, last_mv + 1);
    end
    checks++;
    if (end_dr !== old || drdata_bad != 0) begin
      errors++; $display("FAIL write_drdata_hold: got %h required %h", end_dr, old);
    end
    checks++;
    if (end_dready !== 1'b1 || dready_bad != 0 || err_cnt != 0) begin
      errors++; $display("FAIL write_dready: end %b bad %0d derr %0d required 1/0/0", end_dready, dready_bad, err_cnt);
    end
  endtask

  task automatic test_read;
    run_txn(1'b0, 12'h010, 8'h00, 0, 3, 0, 8'h3C, 1'b1, 1'b0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL read_timeout: no completion in 400 cycles"); end
    checks++;
    if (nbits != AW || got_bits[AW-1:0] !== 12'h010) begin
      errors++; $display("FAIL read_addr: got %0d bits value %h required 12 bits 010", nbits, got_bits[AW-1:0]);
    end
    checks++;
    if (end_dr !== 8'h3C) begin errors++; $display("FAIL read_drdata: got %h required 3c", end_dr); end
    checks++;
    if (done_cnt != 1 || done_cyc != last_sv + 1) begin
      errors++; $display("FAIL read_ddone: got %0d pulses at %0d required 1 at %0d", done_cnt, done_cyc, last_sv + 1);
    end
    checks++;
    if (drdata_bad != 0) begin errors++; $display("FAIL read_drdata_early: %0d cycles changed before done", drdata_bad); end
  endtask

  task automatic test_split;
    run_txn(1'b0, 12'hABC, 8'h00, 1, 0, 5, 8'hA5, 1'b1, 1'b0);
    checks++;
    if (mbreq_low != 5) begin errors++; $display("FAIL split_mbreq: low %0d cycles required 5", mbreq_low); end
    checks++;
    if (end_dr !== 8'hA5) begin errors++; $display("FAIL split_drdata: got %h required a5", end_dr); end
    checks++;
    if (done_cnt != 1 || err_cnt != 0) begin
      errors++; $display("FAIL split_done: ddone %0d derr %0d required 1/0", done_cnt, err_cnt);
    end
  endtask

  task automatic test_timeout;
    logic [DW-1:0] old;
    old = exp_drdata;
    run_txn(1'b0, 12'h7FF, 8'h00, 0, 0, 0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (err_cnt != 1 || err_cyc != last_mv + TO) begin
      errors++; $display("FAIL timeout_derr: got %0d pulses at %0d required 1 at %0d", err_cnt, err_cyc, last_mv + TO);
    end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL timeout_ddone: got %0d pulses required 0", done_cnt); end
    checks++;
    if (end_dr !== old) begin errors++; $display("FAIL timeout_drdata: got %h required %h", end_dr, old); end
    checks++;
    if (end_dready !== 1'b1) begin errors++; $display("FAIL timeout_idle: dready %b required 1", end_dready); end
  endtask

  task automatic test_grant_wait;
    run_txn(1'b1, 12'h123, 8'h45, 10, 0, 0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (mbreq_low != 0) begin errors++; $display("FAIL grant_mbreq: low %0d cycles required 0", mbreq_low); end
    checks++;
    if (first_mv != 12) begin errors++; $display("FAIL grant_first_mvalid: cycle %0d required 12", first_mv); end
    checks++;
    if (got_bits !== {8'h45, 12'h123} || done_cnt != 1) begin
      errors++; $display("FAIL grant_transfer: bits %h done %0d required 45123/1", got_bits, done_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int nb;
    bit hit;
    nb = 0; hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      bus.dvalid = (c == 0); bus.dmode = 1'b1; bus.daddr = 12'h3C5; bus.dwdata = 8'h96;
      bus.mgrant = 1'b1; bus.sready = 1'b1;
      #1;
      if (bus.mvalid === 1'b1) nb++;
      if (nb == 5) begin rst = 1'b1; hit = 1'b1; end
    end
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    #1;
    checks++;
    if (!hit || {bus.mvalid, bus.mbreq, bus.dready, bus.ddone} !== 4'b0010) begin
      errors++; $display("FAIL reset_mid_idle: hit %b mvalid/mbreq/dready/ddone %b required 0010", hit,
                         {bus.mvalid, bus.mbreq, bus.dready, bus.ddone});
    end
    exp_drdata = '0;
    checks++;
    if (bus.drdata !== '0) begin errors++; $display("FAIL reset_mid_drdata: got %h required 00", bus.drdata); end
    run_txn(1'b1, 12'h0F1, 8'h5E, 0, 0, 0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (got_bits !== {8'h5E, 12'h0F1} || nbits != 20 || done_cnt != 1) begin
      errors++; $display("FAIL reset_mid_recover: bits %h n %0d done %0d required 5e0f1/20/1", got_bits, nbits, done_cnt);
    end
  endtask

  task automatic test_random;
    bit mode, resp;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, rd, old, want_dr;
    logic [AW+DW-1:0] want_bits;
    int gd, pre, ns, want_n, want_done;
    for (int t = 0; t < 30; t++) begin
      mode = 1'($urandom % 2);
      addr = AW'($urandom);
      wd   = DW'($urandom);
      rd   = DW'($urandom);
      gd   = int'($urandom % 6);
      pre  = int'($urandom % 7);
      ns   = (($urandom % 2) == 0) ? 0 : int'($urandom_range(1, 4));
      resp = ($urandom % 8) != 0;
      old  = exp_drdata;
      run_txn(mode, addr, wd, gd, pre, ns, rd, resp, 1'b1);
      // transaction-level expectations
      want_n    = mode ? AW + DW : AW;
      want_bits = mode ? {wd, addr} : {{DW{1'b0}}, addr};
      want_dr   = (!mode && resp) ? rd : old;
      want_done = mode ? last_mv + 1 : last_sv + 1;
      checks++;
      if (timed_out || nbits != want_n || got_bits !== want_bits || last_mv - first_mv + 1 != nbits) begin
        errors++; $display("FAIL rand%0d_stream: n %0d bits %h required n %0d bits %h", t, nbits, got_bits, want_n, want_bits);
      end
      checks++;
      if (first_mv != gd + 2 || mmode_bad != 0) begin
        errors++; $display("FAIL rand%0d_start: first mvalid %0d mmode_bad %0d required %0d/0", t, first_mv, mmode_bad, gd + 2);
      end
      checks++;
      if (mode || resp) begin
        if (done_cnt != 1 || err_cnt != 0 || done_cyc != want_done) begin
          errors++; $display("FAIL rand%0d_done: ddone %0d at %0d derr %0d required 1 at %0d, 0", t, done_cnt, done_cyc, err_cnt, want_done);
        end
      end else if (err_cnt != 1 || done_cnt != 0 || err_cyc != last_mv + TO) begin
        errors++; $display("FAIL rand%0d_derr: derr %0d at %0d ddone %0d required 1 at %0d, 0", t, err_cnt, err_cyc, done_cnt, last_mv + TO);
      end
      checks++;
      if (end_dr !== want_dr || drdata_bad != 0) begin
        errors++; $display("FAIL rand%0d_drdata: got %h early %0d required %h", t, end_dr, drdata_bad, want_dr);
      end
      checks++;
      if (mbreq_low != ((!mode && resp) ? ns : 0)) begin
        errors++; $display("FAIL rand%0d_mbreq: low %0d required %0d", t, mbreq_low, (!mode && resp) ? ns : 0);
      end
      checks++;
      if (dready_bad != 0 || end_dready !== 1'b1) begin
        errors++; $display("FAIL rand%0d_dready: bad %0d end %b required 0/1", t, dready_bad, end_dready);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_write();
    test_read();
    test_split();
    test_timeout();
    test_grant_wait();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
